mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TAG_WIDTH, default 4, width of the writeback scoreboard tag.
REQ-002 Parameter MISALIGN_EXC_EN, default 1, 1 = misaligned access raises exception; 0 = access issued with addr[1:0] forced to 0.
REQ-003 Clocking is decided: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 lsu_en_mem  in  1  memory access request from EX register.
REQ-007 lsu_op_mem  in  1  0 = load, 1 = store.
REQ-008 lsu_dtype_mem  in  3  000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
REQ-009 lsu_addr_mem  in  32  byte address.
REQ-010 rd_wr_en_mem / rd_wr_tag_mem / rd_wr_addr_mem  in  1 / TAG_WIDTH / 5  destination write control.
REQ-011 rd_wr_data_mem  in  32  ALU result, or store data when lsu_op_mem = 1.
REQ-012 pc_mem  in  32  instruction PC; exc_taken_mem  in  1  earlier-stage exception.
REQ-013 ready_mem  out  1  MEM completes this cycle; EX may advance.
REQ-014 data_req  out  1  bus request; data_we  out  1  write enable.
REQ-015 data_be  out  4  byte enables; data_addr  out  32  word-aligned address.
REQ-016 data_wdata  out  32  lane-replicated store data.
REQ-017 data_gnt  in  1  request accepted; data_rvalid  in  1  response valid; data_rdata  in  32  read data.
REQ-018 rd_wr_en_wb / rd_wr_tag_wb / rd_wr_addr_wb / rd_wr_data_wb  out  1 / TAG_WIDTH / 5 / 32  registered writeback.
REQ-019 pc_wb  out  32; exc_taken_wb  out  1; lsu_misalign_wb  out  1  registered to WB.

Function
REQ-020 FSM states IDLE, WAIT_GNT, WAIT_RVALID; one outstanding transaction maximum.
REQ-021 Access = lsu_en_mem & ~exc_taken_mem & ~misaligned; misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 IDLE/WAIT_GNT: data_req = access, combinational from inputs (EX holds them while ready_mem=0); data_gnt=1 -> WAIT_RVALID, else WAIT_GNT.
REQ-023 WAIT_RVALID: data_req=0; data_rvalid=1 -> ready_mem=1, go IDLE; loads and stores both wait rvalid.
REQ-024 Not an access (bubble, exception, misaligned): ready_mem=1 same cycle, no bus request.
REQ-025 data_rvalid in IDLE or WAIT_GNT ignored; data_gnt with data_req=0 ignored.
REQ-026 data_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],0}; word 4'b1111; data_wdata = byte x4 / half x2 / word.
REQ-027 Load result: lane by addr[1:0], sign-extend dtypes 000/001, zero-extend 100/101.
REQ-028 Any edge with ready_mem=1: *_wb <= inputs; rd_wr_data_wb <= load result for loads; rd_wr_en_wb <= rd_wr_en_mem & ~store & ~exc.
REQ-029 Misaligned with MISALIGN_EXC_EN=1: exc_taken_wb=1, lsu_misalign_wb=1, rd_wr_en_wb=0.
REQ-030 Edge with ready_mem=0: rd_wr_en_wb, exc_taken_wb, lsu_misalign_wb <= 0; other WB registers hold.
REQ-031 Minimum latency: gnt in request cycle, rvalid next cycle -> ready_mem high 1 cycle after request, WB valid 2 cycles after.

Reset
REQ-032 reset=1 asynchronously: state IDLE, all *_wb and pc_wb = 0; data_req, data_we, data_be output 0 while reset is asserted.
REQ-033 Reset mid-transaction abandons the access; a later data_rvalid in IDLE has no effect.

Verification
REQ-034 Load word 0x100, gnt cycle 0, rvalid cycle 1, rdata 0xDEADBEEF -> ready_mem=1 cycle 1; rd_wr_data_wb=0xDEADBEEF cycle 2.
REQ-035 Load byte signed addr 0x103, rdata 0x80112233 -> data_be=0b1000, rd_wr_data_wb=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Store half addr 0x202, data 0x0000ABCD, gnt stalled 3 cycles -> data_req held 4 cycles, be=0b1100, wdata=0xABCDABCD, ready_mem low until rvalid.
REQ-037 Load word addr 0x101 -> no data_req, ready_mem=1, exc_taken_wb=1, lsu_misalign_wb=1, rd_wr_en_wb=0.
REQ-038 Reset pulse in WAIT_RVALID, then stray rvalid -> state IDLE, rd_wr_en_wb=0, no writeback.
REQ-039 Bubble lsu_en_mem=0, rd_wr_en_mem=1, data 0x55 -> ready_mem=1 same cycle, rd_wr_data_wb=0x55 next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: data_req is held with stable address/controls until a cycle with
// data_gnt=1 accepts it; exactly one data_rvalid cycle later completes it.
// Loads and stores both return data_rvalid. At most one request is outstanding.
interface mem_stage_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one load/store on the data bus, formats load data
// and registers the writeback bundle toward WB.
module mem_stage #(
  parameter int TAG_WIDTH       = 4,
  parameter int MISALIGN_EXC_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lsu_en_mem,
  input  logic                 lsu_op_mem,
  input  logic [2:0]           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic [31:0]          pc_mem,
  input  logic                 exc_taken_mem,
  output logic                 ready_mem,
  mem_stage_if.master          data_if,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic [31:0]          pc_wb,
  output logic                 exc_taken_wb,
  output logic                 lsu_misalign_wb,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_e;

  localparam logic EXC_EN = (MISALIGN_EXC_EN != 0);

  state_e state;
  state_e state_next;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_unsigned;
  logic        mis_raw;
  logic        misaligned;
  logic [1:0]  eff_off;
  logic        access;
  logic        exc_all;
  logic        is_store;
  logic        is_load_ok;
  logic        req;
  logic        ready;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] lane_data;
  logic [31:0] load_res;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  always_comb begin
    is_byte     = (lsu_dtype_mem[1:0] == 2'b00);
    is_half     = (lsu_dtype_mem[1:0] == 2'b01);
    is_word     = ~is_byte & ~is_half;
    is_unsigned = lsu_dtype_mem[2];
    mis_raw     = (is_half & lsu_addr_mem[0]) | (is_word & (|lsu_addr_mem[1:0]));
    misaligned  = lsu_en_mem & mis_raw & EXC_EN;
    // With the exception disabled a misaligned access still goes out, word-aligned.
    eff_off     = (mis_raw & ~EXC_EN) ? 2'b00 : lsu_addr_mem[1:0];
    exc_all     = exc_taken_mem | misaligned;
    access      = lsu_en_mem & ~exc_taken_mem & ~misaligned;
    is_store    = lsu_en_mem & lsu_op_mem;
    is_load_ok  = lsu_en_mem & ~lsu_op_mem & ~exc_all;
  end

  // ---------------------------------------------------------------------------
  // Byte enables and store data lane replication
  // ---------------------------------------------------------------------------
  always_comb begin
    be    = 4'b1111;
    wdata = rd_wr_data_mem;
    if (is_byte) begin
      be    = 4'b0001 << eff_off;
      wdata = {4{rd_wr_data_mem[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << {eff_off[1], 1'b0};
      wdata = {2{rd_wr_data_mem[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_data = data_if.data_rdata >> {eff_off, 3'b000};
    load_res  = lane_data;
    if (is_byte) begin
      load_res = {{24{~is_unsigned & lane_data[7]}}, lane_data[7:0]};
    end else if (is_half) begin
      load_res = {{16{~is_unsigned & lane_data[15]}}, lane_data[15:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE, WAIT_GNT: begin
        // EX holds its outputs while ready_mem=0, so req can stay combinational.
        req   = access;
        ready = ~access;
        if (access) begin
          state_next = data_if.data_gnt ? WAIT_RVALID : WAIT_GNT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (data_if.data_rvalid) begin
          ready      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready_mem          = ready;
  assign state_dbg          = state;
  assign data_if.data_req   = req & ~reset;
  assign data_if.data_we    = req & lsu_op_mem & ~reset;
  assign data_if.data_be    = (req & ~reset) ? be : 4'b0000;
  assign data_if.data_addr  = {lsu_addr_mem[31:2], 2'b00};
  assign data_if.data_wdata = wdata;

  // ---------------------------------------------------------------------------
  // Writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_wr_en_wb     <= 1'b0;
      rd_wr_tag_wb    <= '0;
      rd_wr_addr_wb   <= 5'd0;
      rd_wr_data_wb   <= 32'd0;
      pc_wb           <= 32'd0;
      exc_taken_wb    <= 1'b0;
      lsu_misalign_wb <= 1'b0;
    end else if (ready) begin
      rd_wr_en_wb     <= rd_wr_en_mem & ~is_store & ~exc_all;
      rd_wr_tag_wb    <= rd_wr_tag_mem;
      rd_wr_addr_wb   <= rd_wr_addr_mem;
      rd_wr_data_wb   <= is_load_ok ? load_res : rd_wr_data_mem;
      pc_wb           <= pc_mem;
      exc_taken_wb    <= exc_all;
      lsu_misalign_wb <= misaligned;
    end else begin
      // Stalled: WB sees a bubble, payload registers keep their last value.
      rd_wr_en_wb     <= 1'b0;
      exc_taken_wb    <= 1'b0;
      lsu_misalign_wb <= 1'b0;
    end
  end

endmodule
